// File: rtl/addsub_pipe_pkg.sv
// Shared FIR datapath types for the pipelined adder/subtractor: operation
// encoding, per-stage control bits and the default-width stage layout.
package FirPkg;

  localparam int DATA_WIDTH  = 32;
  localparam int CHUNK_WIDTH = 4;

  typedef enum logic {
    ADD = 1'b0,
    SUB = 1'b1
  } addsub_op_t;

  // Control bits that ride alongside the data through every stage.
  typedef struct packed {
    logic       valid;
    addsub_op_t op;
    logic       sat;
    logic       sgn;
  } addsub_ctrl_t;

  // Full stage record at the package's default width.
  typedef struct packed {
    addsub_ctrl_t            ctrl;
    logic                    carry;
    logic                    c_msb_in;
    logic [DATA_WIDTH-1:0]   a;
    logic [DATA_WIDTH-1:0]   b;
    logic [DATA_WIDTH-1:0]   s;
  } addsub_stage_t;

endpackage

// File: rtl/addsub_pipe_chunk.sv
// One CHUNK_WIDTH-bit ripple slice of the add/sub carry chain. Purely
// combinational; b is inverted here when sub_i is set.
module addsub_chunk #(
  parameter int CHUNK_WIDTH = 4
) (
  input  logic [CHUNK_WIDTH-1:0] a_i,
  input  logic [CHUNK_WIDTH-1:0] b_i,
  input  logic                   sub_i,
  input  logic                   cin_i,
  output logic [CHUNK_WIDTH-1:0] s_o,
  output logic                   cout_o,
  output logic                   c_msb_in_o
);

  logic [CHUNK_WIDTH-1:0] w_bx;
  logic [CHUNK_WIDTH:0]   w_c;

  assign w_bx = b_i ^ {CHUNK_WIDTH{sub_i}};

  always_comb begin
    w_c    = '0;
    w_c[0] = cin_i;
    for (int i = 0; i < CHUNK_WIDTH; i++) begin
      w_c[i+1] = (a_i[i] & w_bx[i]) | (w_c[i] & (a_i[i] ^ w_bx[i]));
    end
  end

  assign s_o        = a_i ^ w_bx ^ w_c[CHUNK_WIDTH-1:0];
  assign cout_o     = w_c[CHUNK_WIDTH];
  assign c_msb_in_o = w_c[CHUNK_WIDTH-1];

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined add/sub: the carry chain is cut into CHUNK_WIDTH slices, one
// registered stage each, followed by a saturation/flag result stage.
module addsub_pipe
  import FirPkg::*;
#(
  parameter int DATA_WIDTH  = FirPkg::DATA_WIDTH,
  parameter int CHUNK_WIDTH = FirPkg::CHUNK_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  addsub_op_t            op_i,
  input  logic                  sat_i,
  input  logic                  signed_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] s_o,
  output logic                  carry_o,
  output logic                  v_o,
  output logic                  z_o,
  output logic                  n_o
);

  localparam int NSTG = DATA_WIDTH / CHUNK_WIDTH;

  typedef struct packed {
    addsub_ctrl_t          ctrl;
    logic                  carry;
    logic                  c_msb_in;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [DATA_WIDTH-1:0] s;
  } stage_t;

  stage_t                             w_in  [NSTG];
  stage_t                             w_out [NSTG];
  stage_t                             r_stg [NSTG];
  logic   [NSTG-1:0][CHUNK_WIDTH-1:0] w_sum;
  logic   [NSTG-1:0]                  w_cout;
  logic   [NSTG-1:0]                  w_cmsb;
  logic                               w_adv;

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_s;
  logic                  r_carry;
  logic                  r_v;
  logic                  r_z;
  logic                  r_n;

  // Handshake: one global enable. Every stage shifts (bubbles included) when
  // the output is empty or being taken (adv = ready_i | ~valid_o); otherwise
  // the whole pipe holds. Input transfer = valid_i & ready_o, output transfer
  // = valid_o & ready_i, and ready_o is exactly adv.
  assign w_adv   = ready_i | ~r_valid;
  assign ready_o = w_adv;

  // Stage k's input is the previous stage register; stage 0 takes the ports,
  // with the op bit doubling as the initial carry (a + ~b + 1 for SUB).
  always_comb begin
    w_in[0] = '{ctrl:     '{valid: valid_i, op: op_i, sat: sat_i, sgn: signed_i},
                carry:    (op_i == SUB),
                c_msb_in: 1'b0,
                a:        a_i,
                b:        b_i,
                s:        '0};
    for (int k = 1; k < NSTG; k++) begin
      w_in[k] = r_stg[k-1];
    end
  end

  for (genvar k = 0; k < NSTG; k++) begin : g_chunk
    addsub_chunk #(
      .CHUNK_WIDTH(CHUNK_WIDTH)
    ) u_chunk (
      .a_i       (w_in[k].a[k*CHUNK_WIDTH +: CHUNK_WIDTH]),
      .b_i       (w_in[k].b[k*CHUNK_WIDTH +: CHUNK_WIDTH]),
      .sub_i     (w_in[k].ctrl.op == SUB),
      .cin_i     (w_in[k].carry),
      .s_o       (w_sum[k]),
      .cout_o    (w_cout[k]),
      .c_msb_in_o(w_cmsb[k])
    );
  end

  always_comb begin
    for (int k = 0; k < NSTG; k++) begin
      w_out[k]          = w_in[k];
      w_out[k].carry    = w_cout[k];
      w_out[k].c_msb_in = w_cmsb[k];
      w_out[k].s[k*CHUNK_WIDTH +: CHUNK_WIDTH] = w_sum[k];
    end
  end

  // Only the valid bits need reset; data fields follow whatever shifts in.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < NSTG; k++) begin
        r_stg[k].ctrl.valid <= 1'b0;
      end
    end else if (w_adv) begin
      for (int k = 0; k < NSTG; k++) begin
        r_stg[k] <= w_out[k];
      end
    end
  end

  stage_t                w_last;
  logic [DATA_WIDTH-1:0] w_res;
  logic                  w_v;
  logic                  w_unused;

  assign w_last   = r_stg[NSTG-1];
  assign w_v      = w_last.c_msb_in ^ w_last.carry;
  assign w_unused = ^{w_last.a, w_last.b};

  always_comb begin
    w_res = w_last.s;
    if (w_last.ctrl.sat) begin
      if (w_last.ctrl.sgn) begin
        if (w_v) begin
          // Overflowed sum has the wrong sign: MSB set means positive overflow.
          w_res = w_last.s[DATA_WIDTH-1] ? {1'b0, {(DATA_WIDTH-1){1'b1}}}
                                         : {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end
      end else if ((w_last.ctrl.op == ADD) && w_last.carry) begin
        w_res = '1;
      end else if ((w_last.ctrl.op == SUB) && !w_last.carry) begin
        w_res = '0;
      end
    end
  end

  // Result registers load only on real results so outputs stay 0 after reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
      r_s     <= '0;
      r_carry <= 1'b0;
      r_v     <= 1'b0;
      r_z     <= 1'b0;
      r_n     <= 1'b0;
    end else if (w_adv) begin
      r_valid <= w_last.ctrl.valid;
      if (w_last.ctrl.valid) begin
        r_s     <= w_res;
        r_carry <= w_last.carry;
        r_v     <= w_v;
        r_z     <= (w_res == '0);
        r_n     <= w_res[DATA_WIDTH-1];
      end
    end
  end

  assign valid_o = r_valid;
  assign s_o     = r_s;
  assign carry_o = r_carry;
  assign v_o     = r_v;
  assign z_o     = r_z;
  assign n_o     = r_n;

endmodule

// File: doc/addsub_pipe.md
# addsub_pipe

Pipelined, parametrised adder/subtractor for the FIR datapath. It is the successor of the single-cycle ripple add/sub. The carry chain is split into registered chunks so that DATA_WIDTH can grow without lengthening the critical path. It adds per-operation signed/unsigned saturation, result flags, and a valid/ready handshake. It sits between the tap multipliers and the accumulator, and anywhere else a wide add/sub must meet timing.

## Interface
- DATA_WIDTH, default FirPkg::DATA_WIDTH (32): operand/result width; must be a multiple of CHUNK_WIDTH.
- CHUNK_WIDTH, default 4: bits resolved per pipeline stage; must be ≥ 2.
- clk_i  in  1  clock; all state changes on its rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- valid_i  in  1  input operation valid.
- ready_o  out  1  block accepts an operation this cycle.
- a_i, b_i  in  DATA_WIDTH  operands.
- op_i  in  addsub_op_t  ADD = 0 (a+b), SUB = 1 (a−b = a+~b+1).
- sat_i  in  1  saturate the result instead of wrapping.
- signed_i  in  1  two's-complement (1) or unsigned (0) interpretation, used for saturation.
- valid_o  out  1  result valid.
- ready_i  in  1  downstream accepts the result.
- s_o  out  DATA_WIDTH  result.
- carry_o  out  1  raw carry out of the MSB; for SUB, 1 means no borrow.
- v_o  out  1  signed overflow (carry into MSB XOR carry out); always reported.
- z_o, n_o  out  1  final s_o is zero / final s_o MSB.

## Operation
- NSTG = DATA_WIDTH/CHUNK_WIDTH chunk stages, followed by one result stage. Total stages L = NSTG+1.
- Stage k (0-based) adds chunk k of a and (b XOR op), with carry-in:
  - from stage k−1's registered carry, or
  - op_i for k = 0.
- Chunk k registers its sum bits, its carry-out and its carry into its MSB.
  - Operand chunks > k are carried forward unchanged (input skew).
  - Result chunks < k are carried forward (output deskew).
- op, sat, signed and valid travel with the data through every stage.
- Result stage computes, from the stage NSTG−1 output:
  - raw sum R, carry C, and V = c_msb_in ^ C.
  - Saturation applies only when sat = 1:
    - unsigned ADD with C = 1 → all ones;
    - unsigned SUB with C = 0 → all zeros;
    - signed with V = 1 → 0x7F..F if R MSB = 1 (positive overflow), 0x80..0 otherwise.
  - Otherwise s_o = R.
  - carry_o = C and v_o = V regardless of saturation; z_o and n_o reflect the final s_o.
- Handshake uses a global enable: adv = ready_i | ~valid_o, and ready_o = adv.
  - All stages shift only when adv = 1; when adv = 0 every stage holds.
  - A transfer in occurs on valid_i & ready_o.
  - A transfer out occurs on valid_o & ready_i.
  - Bubbles (valid = 0) shift like data; they are not collapsed.
- Reset clears every stage valid bit. Data registers need not be reset, but all outputs must read 0 while reset is asserted and afterwards until the first result.

## Timing
- Latency: exactly L cycles from accept to valid_o, with no stalls.
- Throughput: 1 operation/cycle when ready_i is held at 1.
- ready_o is combinational from ready_i and valid_o. There is no other combinational input→output path.
- While valid_o = 1 and ready_i = 0:
  - s_o and all flags are held stable;
  - ready_o = 0.
- Reset values of all outputs are 0 (s_o, carry_o, v_o, z_o, n_o, valid_o). ready_o is 1 during and after reset.
- Reset asserted mid-operation: all in-flight operations are discarded on that edge. valid_o = 0 on the next cycle.
- Simultaneous events:
  - output transfer plus input accept in the same cycle is legal;
  - pipeline occupancy never exceeds L.

## Structure
- FirPkg adds:
  - CHUNK_WIDTH default;
  - typedef enum logic {ADD, SUB} addsub_op_t;
  - a stage struct typedef (valid, op, sat, signed, carry, c_msb_in, a, b, s).
- Sub-module addsub_chunk: one combinational CHUNK_WIDTH ripple slice with inputs a, b, sub, cin and outputs s, cout, c_msb_in. It is instantiated NSTG times in a generate loop. Stage registers live in addsub_pipe.

## Test plan
Test configuration: DATA_WIDTH = 16, CHUNK_WIDTH = 4, L = 5.
- Basic add: reset, then ADD 0x1234 + 0x0FFF with sat = 0.
  - Expect valid_o exactly 5 cycles after accept; s_o = 0x2233, carry_o = 0, v_o = 0.
- Signed saturation: SUB signed sat = 1, 0x8000 − 0x0001.
  - Expect s_o = 0x8000 (min negative), v_o = 1.
  - Same with sat = 0 → s_o = 0x7FFF, v_o = 1.
- Unsigned saturation:
  - ADD unsigned sat = 1, 0xFFF0 + 0x0020 → s_o = 0xFFFF, carry_o = 1.
  - SUB unsigned sat = 1, 0x0005 − 0x0009 → s_o = 0x0000, z_o = 1, carry_o = 0.
- Streaming with backpressure: 100 random back-to-back operations with ready_i toggled randomly.
  - All results match the scoreboard in order, with no loss or duplication.
  - Outputs stay stable while stalled, and ready_o = 0 whenever valid_o & ~ready_i.
- Reset mid-flight: accept 3 operations, then assert rst_i for 1 cycle.
  - valid_o = 0 for the next 5 cycles with no stale result emitted.
  - Next accepted operation emerges after exactly 5 cycles.
